regfile_writer: RTL

Write-side controller for the small register file used in the RegFile analysis designs. It accepts write requests over a valid/ready handshake and drives the register file write port. After each write it reads the same register back and compares it with the written data. It reports one pass/fail completion per request and keeps a saturating mismatch counter. It is the producer counterpart to the equality/flag logic on the register file read side.

---
 rtl/regfile_writer_pkg.sv | 15 +
 rtl/coreir_eq.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/regfile_writer.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_writer_pkg.sv
// Shared types and constants for the register file write-side controller.
// Contents:
//   state_t        FSM state encoding (IDLE, WRITE, CHECK; 2'd3 is unused)
//   DEFAULT_ERR_W  default width of the readback mismatch counter
package regfile_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_ERR_W = 8;

endpackage

// File: rtl/coreir_eq.sv
// Equality comparator.
// Ports:
//   in0, in1  operands
//   out       1 when in0 == in1
module coreir_eq #(
  parameter int unsigned width = 1
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic             out
);

  assign out = (in0 == in1);

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, clears the count
//   inc    count up by one (ignored at all-ones)
//   clear  synchronous clear, has priority over inc
//   count  current value
module sat_counter #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [ERR_W-1:0] count
);

  logic [ERR_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {ERR_W{1'b1}})) begin
      count_q <= count_q + ERR_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_writer.sv
// Write-side controller for a small register file. Accepts one write request
// over valid/ready, issues it on the write port, reads the same register back
// the next cycle and reports a pass/fail completion pulse. Readback mismatches
// are counted in a saturating counter.
// Ports:
//   CLK, ASYNCRESETN          clock and asynchronous active-low reset
//   req_valid/ready/addr/data write request handshake
//   wr_en/addr/data           register file write port
//   rd_addr, rd_data          register file read port (combinational read)
//   done_valid, done_ok       completion pulse and readback match flag
//   err_count                 saturating mismatch count
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREGS  = 2,
  parameter int unsigned ERR_W  = DEFAULT_ERR_W,
  localparam int unsigned ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              done_valid,
  output logic              done_ok,
  output logic [ERR_W-1:0]  err_count
);

  state_t            state_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [WIDTH-1:0]  hold_data_q;
  logic              wr_en_q;
  logic              data_eq;

  // wr_en is a flop with async reset, so reset drops it without a clock edge.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            hold_addr_q <= req_addr;
            hold_data_q <= req_data;
            wr_en_q     <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE:   state_q <= CHECK;
        CHECK:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  coreir_eq #(
    .width (WIDTH)
  ) u_eq (
    .in0 (hold_data_q),
    .in1 (rd_data),
    .out (data_eq)
  );

  sat_counter #(
    .ERR_W (ERR_W)
  ) u_err_cnt (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .inc   (done_valid && !data_eq),
    .clear (1'b0),
    .count (err_count)
  );

  assign req_ready  = (state_q == IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = hold_addr_q;
  assign wr_data    = hold_data_q;
  assign rd_addr    = hold_addr_q;
  assign done_valid = (state_q == CHECK);
  assign done_ok    = done_valid && data_eq;

endmodule
